// File: rtl/miner_pkg.sv
// Shared widths, state encoding and helpers for the miner job controller.
// The core input word is {nonce, header}, so CORE_DATA_W is their sum.
package miner_pkg;

  localparam int HEADER_W    = 608;
  localparam int TARGET_W    = 256;
  localparam int NONCE_W     = 32;
  localparam int CORE_DATA_W = NONCE_W + HEADER_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Counter width that stays legal (>=1 bit) for an interval of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miner_nonce_fifo.sv
// In-flight nonce FIFO: one entry per nonce handed to the hash core, popped in issue order.
// The head is readable combinationally so a result can be paired with its nonce in the same cycle.
module miner_nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_push,
  input  logic [NONCE_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [NONCE_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [AW:0]        o_count
);

  logic [NONCE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/miner_job_ctrl.sv
// Sequences one odo_keccak core over a nonce range: paced issue, in-flight tracking,
// result/nonce pairing and a valid/ready hit port towards the host.
module miner_job_ctrl
  import miner_pkg::*;
#(
  parameter int ISSUE_INTERVAL = 1000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [HEADER_W-1:0]    job_header,
  input  logic [TARGET_W-1:0]    job_target,
  input  logic [NONCE_W-1:0]     job_nonce_start,
  input  logic [NONCE_W-1:0]     job_nonce_end,
  input  logic                   abort,
  output logic [CORE_DATA_W-1:0] core_data,
  output logic [TARGET_W-1:0]    core_target,
  output logic                   core_advance,
  input  logic                   core_has_res,
  input  logic                   core_res,
  output logic                   found_valid,
  output logic [NONCE_W-1:0]     found_nonce,
  input  logic                   found_ready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            hashes_done,
  output logic                   found_lost
);

  localparam int CNT_W   = cnt_width(ISSUE_INTERVAL);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ISSUE_INTERVAL - 1);
  localparam logic [FIFO_AW:0]   ONE_ENTRY = (FIFO_AW+1)'(1);

  state_t              r_state;
  logic [HEADER_W-1:0] r_header;
  logic [TARGET_W-1:0] r_target;
  logic [NONCE_W-1:0]  r_nonce_cur;
  logic [NONCE_W-1:0]  r_nonce_end;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_hashes_done;
  logic                r_found_valid;
  logic [NONCE_W-1:0]  r_found_nonce;
  logic                r_found_lost;
  logic                r_done;

  logic                w_full;
  logic                w_empty;
  logic [NONCE_W-1:0]  w_head;
  logic [FIFO_AW:0]    w_count;
  logic                w_pop;
  logic                w_at_term;
  logic                w_issue;
  logic                w_hit;
  logic                w_last_pop;

  assign w_pop     = core_has_res && !w_empty;
  assign w_at_term = (r_cnt == CNT_LAST);
  // A full FIFO may still issue when a result frees the head slot in the same cycle.
  assign w_issue   = (r_state == ST_RUN) && w_at_term && !abort && (!w_full || w_pop);
  assign w_hit     = w_pop && core_res;
  assign w_last_pop = w_pop && (w_count == ONE_ENTRY) && !w_issue;

  miner_nonce_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_nonce_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_issue),
    .i_push_data (r_nonce_cur),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign job_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign core_data    = {r_nonce_cur, r_header};
  assign core_target  = r_target;
  assign core_advance = w_issue;
  assign found_valid  = r_found_valid;
  assign found_nonce  = r_found_nonce;
  assign found_lost   = r_found_lost;
  assign done         = r_done;
  assign hashes_done  = r_hashes_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_header      <= '0;
      r_target      <= '0;
      r_nonce_cur   <= '0;
      r_nonce_end   <= '0;
      r_cnt         <= '0;
      r_hashes_done <= '0;
      r_found_valid <= 1'b0;
      r_found_nonce <= '0;
      r_found_lost  <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Result path is live in every state so late results still drain after abort.
      if (w_pop) begin
        r_hashes_done <= r_hashes_done + 32'd1;
      end
      if (core_has_res && w_empty) begin
        r_found_lost <= 1'b1;
      end
      if (w_hit) begin
        if (!r_found_valid || found_ready) begin
          r_found_nonce <= w_head;
          r_found_valid <= 1'b1;
        end else begin
          r_found_lost <= 1'b1;
        end
      end else if (found_ready) begin
        r_found_valid <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (job_valid) begin
            r_header      <= job_header;
            r_target      <= job_target;
            r_nonce_cur   <= job_nonce_start;
            r_nonce_end   <= job_nonce_end;
            r_cnt         <= '0;
            r_hashes_done <= '0;
            r_found_lost  <= 1'b0;
            r_found_valid <= 1'b0;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_DRAIN;
          end else if (w_issue) begin
            r_cnt       <= '0;
            r_nonce_cur <= r_nonce_cur + NONCE_W'(1);
            if (r_nonce_cur == r_nonce_end) begin
              r_state <= ST_DRAIN;
            end
          end else if (!w_at_term) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_empty || w_last_pop) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Bench for miner_job_ctrl: behavioural hash-core model with fixed latency, scoreboards
// for issued nonces and reported hits, plus directed stall, abort, drop and reset cases.
module tb_miner_job_ctrl;
  import miner_pkg::*;

  localparam int II  = 4;
  localparam int FD  = 4;
  localparam int LAT = 6;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   job_valid = 1'b0;
  logic                   job_ready;
  logic [HEADER_W-1:0]    job_header = '0;
  logic [TARGET_W-1:0]    job_target = '0;
  logic [NONCE_W-1:0]     job_nonce_start = '0;
  logic [NONCE_W-1:0]     job_nonce_end = '0;
  logic                   abort = 1'b0;
  logic [CORE_DATA_W-1:0] core_data;
  logic [TARGET_W-1:0]    core_target;
  logic                   core_advance;
  logic                   core_has_res = 1'b0;
  logic                   core_res = 1'b0;
  logic                   found_valid;
  logic [NONCE_W-1:0]     found_nonce;
  logic                   found_ready = 1'b0;
  logic                   busy;
  logic                   done;
  logic [31:0]            hashes_done;
  logic                   found_lost;

  miner_job_ctrl #(
    .ISSUE_INTERVAL (II),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .abort           (abort),
    .core_data       (core_data),
    .core_target     (core_target),
    .core_advance    (core_advance),
    .core_has_res    (core_has_res),
    .core_res        (core_res),
    .found_valid     (found_valid),
    .found_nonce     (found_nonce),
    .found_ready     (found_ready),
    .busy            (busy),
    .done            (done),
    .hashes_done     (hashes_done),
    .found_lost      (found_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0]         exp_issue[$];
  logic [31:0]         exp_found[$];
  logic [31:0]         pend_nonce[$];
  int                  pend_due[$];
  int                  adv_cyc[$];
  bit                  hit_set[logic [31:0]];
  logic [HEADER_W-1:0] exp_header = '0;
  logic [TARGET_W-1:0] exp_target = '0;
  bit                  withhold = 1'b0;
  bit                  track_found = 1'b1;
  bit                  inject_spur = 1'b0;
  int                  rel_req = 0;
  int                  rel_done = 0;
  int                  adv_cnt = 0;
  int                  found_cnt = 0;
  int                  done_cnt = 0;
  int                  accept_cyc = 0;

  // Core model drives results on the falling edge, then the monitor samples the cycle.
  always @(negedge clk) begin
    core_has_res = 1'b0;
    core_res     = 1'b0;
    if (!reset) begin
      if (inject_spur) begin
        core_has_res = 1'b1;
        core_res     = 1'b1;
      end else if (pend_nonce.size() > 0 && pend_due[0] <= cyc &&
                   (!withhold || rel_done < rel_req)) begin
        if (withhold) rel_done++;
        core_has_res = 1'b1;
        core_res     = hit_set.exists(pend_nonce[0]);
        if (core_res && track_found) exp_found.push_back(pend_nonce[0]);
        void'(pend_nonce.pop_front());
        void'(pend_due.pop_front());
      end
    end
    #1;
    if (core_advance) begin
      adv_cnt++;
      adv_cyc.push_back(cyc);
      check_val("issue_expected", 64'(exp_issue.size() != 0), 1);
      if (exp_issue.size() != 0) check_val("issue_nonce", 64'(core_data[639:608]), 64'(exp_issue.pop_front()));
      check_val("issue_header", 64'(core_data[607:0] == exp_header), 1);
      check_val("issue_target", 64'(core_target == exp_target), 1);
      pend_nonce.push_back(core_data[639:608]);
      pend_due.push_back(cyc + LAT);
    end
    if (found_valid) found_cnt++;
    if (found_valid && found_ready && track_found) begin
      check_val("found_expected", 64'(exp_found.size() != 0), 1);
      if (exp_found.size() != 0) check_val("found_nonce", 64'(found_nonce), 64'(exp_found.pop_front()));
    end
    if (done) done_cnt++;
  end

  task automatic push_range(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) exp_issue.push_back(s + 32'(i));
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input int tag);
    logic [31:0] w;
    @(posedge clk); #2;
    w = 32'hC0DE0000 + 32'(tag);
    exp_header = {19{w}};
    exp_target = {8{~w}};
    job_header = exp_header;
    job_target = exp_target;
    job_nonce_start = s;
    job_nonce_end = e;
    check_val("job_ready_idle", 64'(job_ready), 1);
    job_valid = 1'b1;
    accept_cyc = cyc;
    @(posedge clk); #2;
    job_valid = 1'b0;
    check_val("busy_after_accept", 64'(busy), 1);
    $display("job %0d accepted: start=%08h end=%08h", tag, s, e);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    check_val({tag, "_done_seen"}, 64'(done_cnt - d0), 1);
    repeat (3) @(posedge clk);
    #2;
    check_val({tag, "_done_single"}, 64'(done_cnt - d0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int f0;

    repeat (2) @(posedge clk);
    #2;
    check_val("rst_job_ready", 64'(job_ready), 1);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_core_advance", 64'(core_advance), 0);
    check_val("rst_core_data", 64'(core_data == '0), 1);
    check_val("rst_hashes", 64'(hashes_done), 0);
    check_val("rst_found_valid", 64'(found_valid), 0);
    check_val("rst_found_lost", 64'(found_lost), 0);
    check_val("rst_done", 64'(done), 0);
    reset = 1'b0;

    // Job 1: 10..13, no hits, pacing check.
    found_ready = 1'b1;
    push_range(32'd10, 4);
    a0 = adv_cnt; f0 = found_cnt; adv_cyc.delete();
    start_job(32'd10, 32'd13, 1);
    wait_done("s1", 100);
    check_val("s1_pulses", 64'(adv_cnt - a0), 4);
    check_val("s1_adv_cyc_count", 64'(adv_cyc.size()), 4);
    check_val("s1_first_pulse", 64'(adv_cyc[0] - accept_cyc), II);
    check_val("s1_interval", 64'(adv_cyc[1] - adv_cyc[0]), II);
    check_val("s1_hashes", 64'(hashes_done), 4);
    check_val("s1_no_found", 64'(found_cnt - f0), 0);
    check_val("s1_found_lost", 64'(found_lost), 0);
    check_val("s1_idle", 64'(job_ready && !busy), 1);
    check_val("s1_issue_left", 64'(exp_issue.size()), 0);

    // Job 2: hit on 12, host always ready.
    hit_set[32'd12] = 1'b1;
    push_range(32'd10, 4);
    f0 = found_cnt;
    start_job(32'd10, 32'd13, 2);
    wait_done("s2", 100);
    check_val("s2_found_cycles", 64'(found_cnt - f0), 1);
    check_val("s2_found_left", 64'(exp_found.size()), 0);
    check_val("s2_found_lost", 64'(found_lost), 0);
    check_val("s2_hashes", 64'(hashes_done), 4);
    check_val("s2_found_valid", 64'(found_valid), 0);

    // Job 3: range wrapping through 0xFFFFFFFF.
    hit_set.delete();
    push_range(32'hFFFF_FFFE, 4);
    a0 = adv_cnt;
    start_job(32'hFFFF_FFFE, 32'd1, 3);
    wait_done("s3", 100);
    check_val("s3_pulses", 64'(adv_cnt - a0), 4);
    check_val("s3_hashes", 64'(hashes_done), 4);
    check_val("s3_issue_left", 64'(exp_issue.size()), 0);

    // Job 5: two hits with host not ready, second is dropped.
    track_found = 1'b0;
    found_ready = 1'b0;
    hit_set[32'd5] = 1'b1;
    hit_set[32'd6] = 1'b1;
    push_range(32'd5, 2);
    start_job(32'd5, 32'd6, 5);
    wait_done("s5", 100);
    check_val("s5_found_valid_idle", 64'(found_valid), 1);
    check_val("s5_found_nonce", 64'(found_nonce), 5);
    check_val("s5_found_lost", 64'(found_lost), 1);
    check_val("s5_hashes", 64'(hashes_done), 2);
    check_val("s5_job_ready", 64'(job_ready), 1);
    @(posedge clk); #2;
    found_ready = 1'b1;
    @(posedge clk); #2;
    found_ready = 1'b0;
    check_val("s5_found_consumed", 64'(found_valid), 0);
    track_found = 1'b1;
    found_ready = 1'b1;
    hit_set.delete();

    // Job 4: core withholds results, FIFO fills, single release, then abort.
    withhold = 1'b1;
    push_range(32'd100, 5);
    a0 = adv_cnt;
    start_job(32'd100, 32'd200, 4);
    repeat (40) @(posedge clk);
    #2;
    check_val("s4_stall_pulses", 64'(adv_cnt - a0), FD);
    check_val("s4_busy", 64'(busy), 1);
    check_val("s4_hashes_stalled", 64'(hashes_done), 0);
    rel_req++;
    repeat (3) @(posedge clk);
    #2;
    check_val("s4_release_pulse", 64'(adv_cnt - a0), FD + 1);
    check_val("s4_hashes_release", 64'(hashes_done), 1);
    repeat (12) @(posedge clk);
    #2;
    check_val("s4_restall", 64'(adv_cnt - a0), FD + 1);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    withhold = 1'b0;
    wait_done("s4", 60);
    check_val("s4_pulses_after_abort", 64'(adv_cnt - a0), FD + 1);
    check_val("s4_hashes", 64'(hashes_done), FD + 1);
    check_val("s4_issue_left", 64'(exp_issue.size()), 0);

    // Spurious result while idle.
    check_val("s6_lost_before", 64'(found_lost), 0);
    @(posedge clk); #2;
    inject_spur = 1'b1;
    @(posedge clk); #2;
    inject_spur = 1'b0;
    check_val("s6_spur_lost", 64'(found_lost), 1);
    check_val("s6_spur_hashes", 64'(hashes_done), FD + 1);
    check_val("s6_spur_found_valid", 64'(found_valid), 0);
    check_val("s6_spur_idle", 64'(busy), 0);

    // Reset in the middle of a run.
    push_range(32'd0, 2);
    a0 = adv_cnt;
    start_job(32'd0, 32'd1000, 6);
    repeat (8) @(posedge clk);
    #2;
    check_val("s6_pulses_pre_reset", 64'(adv_cnt - a0), 2);
    reset = 1'b1;
    #1;
    exp_issue.delete();
    pend_nonce.delete();
    pend_due.delete();
    check_val("s6_rst_job_ready", 64'(job_ready), 1);
    check_val("s6_rst_busy", 64'(busy), 0);
    check_val("s6_rst_hashes", 64'(hashes_done), 0);
    check_val("s6_rst_found_lost", 64'(found_lost), 0);
    check_val("s6_rst_core_advance", 64'(core_advance), 0);
    check_val("s6_rst_core_target", 64'(core_target == '0), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    inject_spur = 1'b1;
    @(posedge clk); #2;
    inject_spur = 1'b0;
    check_val("s6_fifo_empty_after_reset", 64'(found_lost), 1);
    check_val("s6_hashes_after_reset", 64'(hashes_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
